sm_dbg_ctrl: RTL and testbench

SM_DBG_CTRL -- requirements
Module: sm_dbg_ctrl

---
 rtl/sm_dbg_ctrl.sv | 140 ++++++++++++++
 tb/tb_sm_dbg_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_dbg_ctrl.sv
// Debug controller: debounced run/halt and single-step buttons gate the core clock,
// and a valid/ready byte stream dumps all 32 core registers MSB first.
module sm_dbg_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned STEP_CYC     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnMode,
  input  logic        btnStep,
  input  logic [4:0]  swAddr,
  input  logic        dumpReq,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        clkEnable,
  output logic [31:0] dispData,
  output logic        txValid,
  output logic [7:0]  txData,
  input  logic        txReady,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned StepW = $clog2(STEP_CYC + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StSend} state_e;

  // Bit 0 is the mode button, bit 1 the step button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, db_q, db_prev_q, db_rise;
  logic [DbW-1:0] db_cnt_q [2];

  state_e           state_q;
  logic [4:0]       idx_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      shift_q;
  logic [31:0]      disp_q;
  logic             pend_q;
  logic             run_q;
  logic [StepW-1:0] step_cnt_q;
  logic             step_idle;
  logic             dump_go;

  assign btn_raw = {btnStep, btnMode};
  assign db_rise = db_q & ~db_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      // Counter only runs while the synchronized level differs from the accepted one.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYC - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign step_idle = (step_cnt_q == '0);
  assign busy      = (state_q != StIdle);
  assign dump_go   = (state_q == StIdle) && (pend_q || dumpReq) && step_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      disp_q     <= '0;
      pend_q     <= 1'b0;
      run_q      <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      if (db_rise[0]) run_q <= ~run_q;

      // Step edges are dropped, never queued, unless the step logic is fully idle.
      if (!step_idle) begin
        step_cnt_q <= step_cnt_q - 1'b1;
      end else if (db_rise[1] && !run_q && !busy && !pend_q && !dumpReq) begin
        step_cnt_q <= StepW'(STEP_CYC);
      end

      if (!busy) disp_q <= regData;

      unique case (state_q)
        StIdle: begin
          if (dumpReq) pend_q <= 1'b1;
          if (dump_go) begin
            idx_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          shift_q    <= regData;
          byte_cnt_q <= '0;
          state_q    <= StSend;
        end
        StSend: begin
          if (txReady) begin
            shift_q    <= {shift_q[23:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              if (idx_q != 5'd31) begin
                idx_q   <= idx_q + 1'b1;
                state_q <= StSetup;
              end else begin
                pend_q  <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign regAddr   = busy ? idx_q : swAddr;
  assign dispData  = disp_q;
  assign txValid   = (state_q == StSend);
  assign txData    = shift_q[31:24];
  assign halted    = ~run_q;
  // Drops in the very cycle a dump is accepted so the core is frozen before SETUP reads it.
  assign clkEnable = !busy && !dump_go && (run_q || !step_idle);

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Directed bench for sm_dbg_ctrl: debounce, single step, register dump with
// back-pressure, step/dump interaction, mode toggle mid-dump and reset abort.
module tb_sm_dbg_ctrl;

  logic        clk = 1'b0;
  logic        rst, btnMode, btnStep, dumpReq, txReady;
  logic [4:0]  swAddr, regAddr;
  logic [31:0] regData, dispData;
  logic        clkEnable, txValid, busy, halted;
  logic [7:0]  txData;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Core register file model: each register reads as 0x010203xx with xx = index.
  assign regData = 32'h0102_0300 + {27'd0, regAddr};

  sm_dbg_ctrl #(
    .DEBOUNCE_CYC(4),
    .STEP_CYC    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnMode  (btnMode),
    .btnStep  (btnStep),
    .swAddr   (swAddr),
    .dumpReq  (dumpReq),
    .regAddr  (regAddr),
    .regData  (regData),
    .clkEnable(clkEnable),
    .dispData (dispData),
    .txValid  (txValid),
    .txData   (txData),
    .txReady  (txReady),
    .busy     (busy),
    .halted   (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    w = 32'h0102_0300 + 32'(k / 4);
    return w[31 - 8 * (k % 4) -: 8];
  endfunction

  int          en, first_i, last_i, nbytes, bad_bytes, bad_clk, bad_disp, bad_stall, stall, n;
  int          idle_valid;
  logic        stalled, req_sent, saw_busy, saw_run_busy;
  logic [7:0]  sdata, first_b, last_b;
  logic [4:0]  ra;
  logic [31:0] held;

  initial begin
    rst = 1'b1; btnMode = 1'b0; btnStep = 1'b0; dumpReq = 1'b0; txReady = 1'b1; swAddr = 5'd5;
    cycles(2);
    check_eq("rst_halted", halted, 1);
    check_eq("rst_clk_en", clkEnable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_valid", txValid, 0);
    check_eq("rst_tx_data", txData, 0);
    check_eq("rst_reg_addr", regAddr, 5);
    check_eq("rst_disp", dispData, 0);

    rst = 1'b0;
    cycles(1);
    check_eq("disp_sw5", dispData, 32'h0102_0305);
    swAddr = 5'd7;
    #1 check_eq("reg_addr_sw7", regAddr, 7);
    cycles(1);
    check_eq("disp_sw7", dispData, 32'h0102_0307);

    // Debounce: short glitch ignored, long press toggles once.
    btnMode = 1'b1; cycles(3); btnMode = 1'b0; cycles(12);
    check_eq("glitch_no_toggle", halted, 1);
    btnMode = 1'b1; cycles(10); btnMode = 1'b0; cycles(12);
    check_eq("press_to_run", halted, 0);
    check_eq("run_clk_en", clkEnable, 1);
    btnMode = 1'b1; cycles(10); btnMode = 1'b0; cycles(12);
    check_eq("press_to_halt", halted, 1);
    check_eq("halt_clk_en", clkEnable, 0);

    // Single step with a second press inside the enable window.
    en = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (clkEnable) begin
        en++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      btnStep = (i < 6) || (i >= 12 && i < 18);
    end
    btnStep = 1'b0;
    check_eq("step_cycles", en, 16);
    check_eq("step_contig", last_i - first_i + 1, 16);

    // Full dump in HALT with a 5-cycle stall on byte 10.
    held = dispData;
    dumpReq = 1'b1; cycles(1); dumpReq = 1'b0;
    check_eq("dump_busy", busy, 1);
    check_eq("dump_setup_addr", regAddr, 0);
    nbytes = 0; bad_bytes = 0; bad_clk = 0; bad_disp = 0; bad_stall = 0; stall = 0;
    stalled = 1'b0; first_b = 8'h00; last_b = 8'h00; sdata = 8'h00;
    for (int c = 0; c < 1000 && nbytes < 128; c++) begin
      @(negedge clk);
      if (busy && clkEnable) bad_clk++;
      if (busy && dispData !== held) bad_disp++;
      if (stall > 0) begin
        if (txValid !== 1'b1 || txData !== sdata) bad_stall++;
        stall--;
        if (stall > 0) continue;
        txReady = 1'b1;
      end else if (!stalled && nbytes == 10 && txValid) begin
        stalled = 1'b1; stall = 5; sdata = txData; txReady = 1'b0;
        continue;
      end
      if (txValid && txReady) begin
        if (txData !== exp_byte(nbytes)) bad_bytes++;
        if (nbytes == 0) first_b = txData;
        last_b = txData;
        nbytes++;
      end
    end
    check_eq("dump_byte_count", nbytes, 128);
    check_eq("dump_bad_bytes", bad_bytes, 0);
    check_eq("dump_first_byte", first_b, 8'h01);
    check_eq("dump_last_byte", last_b, 8'h1F);
    check_eq("dump_stall_seen", stalled, 1);
    check_eq("dump_stall_stable", bad_stall, 0);
    check_eq("dump_clk_en_low", bad_clk, 0);
    check_eq("dump_disp_frozen", bad_disp, 0);
    cycles(1);
    check_eq("dump_busy_fall", busy, 0);
    check_eq("dump_valid_fall", txValid, 0);
    idle_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txValid) idle_valid++;
    end
    check_eq("dump_no_extra", idle_valid, 0);

    // dumpReq on the second step cycle: step finishes, then SETUP at register 0.
    en = 0; req_sent = 1'b0; saw_busy = 1'b0; ra = 5'h1F;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin
        saw_busy = 1'b1; ra = regAddr;
        break;
      end
      if (clkEnable) en++;
      btnStep = (i < 6);
      if (dumpReq) dumpReq = 1'b0;
      else if (en == 2 && !req_sent) begin
        dumpReq = 1'b1; req_sent = 1'b1;
      end
    end
    btnStep = 1'b0; dumpReq = 1'b0;
    check_eq("stepdump_cycles", en, 16);
    check_eq("stepdump_busy", saw_busy, 1);
    check_eq("stepdump_addr", ra, 0);

    // Toggle to RUN mid-dump: mode flips at once, clock waits for busy to fall.
    bad_clk = 0; saw_run_busy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (clkEnable) bad_clk++;
      if (!halted) saw_run_busy = 1'b1;
      btnMode = (i < 6);
    end
    btnMode = 1'b0;
    check_eq("toggle_dump_done", busy, 0);
    check_eq("toggle_dump_clk_low", bad_clk, 0);
    check_eq("toggle_mode_early", saw_run_busy, 1);
    check_eq("toggle_run_after", clkEnable, 1);

    // RUN-mode dump: clock drops in the accept cycle; reset during byte 50 aborts.
    dumpReq = 1'b1;
    #1 check_eq("run_dump_clk_drop", clkEnable, 0);
    cycles(1); dumpReq = 1'b0;
    check_eq("run_dump_busy", busy, 1);
    n = 0;
    for (int i = 0; i < 1000 && n < 50; i++) begin
      @(negedge clk);
      if (txValid && txReady) n++;
    end
    cycles(1);
    check_eq("abort_byte50", txData, exp_byte(50));
    rst = 1'b1;
    #1;
    check_eq("abort_valid", txValid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_halted", halted, 1);
    cycles(2); rst = 1'b0;
    idle_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txValid || busy) idle_valid++;
    end
    check_eq("abort_no_resume", idle_valid, 0);
    dumpReq = 1'b1; cycles(1); dumpReq = 1'b0;
    check_eq("redump_addr", regAddr, 0);
    cycles(1);
    check_eq("redump_valid", txValid, 1);
    check_eq("redump_first", txData, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
